multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main controller for the multicycle RV32I core. A Moore FSM steps each
//  instruction through fetch/decode/execute/memory/writeback. It drives the
//  immediate-extender select (immsrc), the mux selects, the ALU control and
//  the write enables. Sits beside the datapath and decodes op/funct fields of
//  the latched instruction register.
// PARAMETERS
//  STATE_W   4   width of state register (>=4; encodings below)
// PORTS
//  clk         in   1  rising-edge clock
//  rst_n       in   1  asynchronous active-low reset
//  op          in   7  instr[6:0] from instruction register
//  funct3      in   3  instr[14:12]
//  funct7b5    in   1  instr[30]
//  zero        in   1  ALU zero flag
//  immsrc      out  2  extender select: 00 I, 01 S, 10 B, 11 J
//  alusrca     out  2  00 PC, 01 OldPC, 10 rd1
//  alusrcb     out  2  00 rd2, 01 immext, 10 const 4
//  resultsrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
//  alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  adrsrc      out  1  memory address: 0 PC, 1 Result
//  irwrite     out  1  latch instr/OldPC
//  pcwrite     out  1  PC load = pcupdate | (branch & zero)
//  memwrite    out  1  data memory write
//  regwrite    out  1  register file write
//  illegal     out  1  sticky illegal-opcode flag (0 if MC_ILLEGAL_TRAP_EN undefined)
// BEHAVIOUR
//  - State reg async-cleared by rst_n=0 to FETCH(0). All outputs are Moore
//    decodes of state: during/after reset they equal FETCH values. Only
//    exception: pcwrite in BEQ (uses zero) and immsrc/alucontrol (from op/funct).
//  - Unlisted outputs 0 in each state; don't-care selects are driven 00.
//  - FETCH(0): adrsrc0 irwrite1 alusrca00 alusrcb10 aluop00 resultsrc10 pcupdate1 ->DECODE
//  - DECODE(1): alusrca01 alusrcb01 aluop00 (branch target) -> by op:
//    0000011/0100011 MEMADR; 0110011 EXECR; 0010011 EXECI; 1101111 JAL;
//    1100011 BEQ; other -> ILLEGAL path (see CONFIGURATION)
//  - MEMADR(2): alusrca10 alusrcb01 aluop00 -> op[5]?MEMWRITE:MEMREAD
//  - MEMREAD(3): resultsrc00 adrsrc1 ->MEMWB.  MEMWB(4): resultsrc01 regwrite ->FETCH
//  - MEMWRITE(5): resultsrc00 adrsrc1 memwrite ->FETCH
//  - EXECR(6): alusrca10 alusrcb00 aluop10 ->ALUWB
//  - EXECI(7): alusrca10 alusrcb01 aluop10 ->ALUWB
//  - ALUWB(8): resultsrc00 regwrite ->FETCH
//  - JAL(9): alusrca01 alusrcb10 aluop00 resultsrc00 pcupdate ->ALUWB
//  - BEQ(10): alusrca10 alusrcb00 aluop01 resultsrc00 branch ->FETCH
//  - Unused encodings -> FETCH next cycle, all enables 0.
//  - Cycle counts: lw 5, sw 4, R/I 4, jal 4, beq 3.
//  - ALU decode: aluop00 add; 01 sub; 10 by funct3: 000 sub iff op[5]&funct7b5
//    else add; 010 slt; 110 or; 111 and; others add.
//  - immsrc comb from op: 0100011 01; 1100011 10; 1101111 11; else 00.
//  - rst_n low mid-instruction: state->FETCH immediately, no write enable
//    asserted while rst_n low except FETCH's irwrite/pcwrite (datapath is reset too).
// CONFIGURATION
//  MC_ILLEGAL_TRAP_EN defined: unknown op in DECODE -> TRAP(11), all enables 0,
//   illegal=1, TRAP self-loops until rst_n; illegal cleared only by reset.
//  Undefined: unknown op in DECODE -> FETCH (skipped as NOP, 2 cycles);
//   illegal tied 0; encoding 11 unused.
// TESTING
//  1 rst_n=0 mid-MEMREAD -> state FETCH async; irwrite=1, pcwrite=1, regwrite=0.
//  2 lw x1 (op 0000011): 5 cycles; MEMWB regwrite=1 resultsrc=01; immsrc=00.
//  3 sw (op 0100011): memwrite=1 exactly 1 cycle, in cycle 4; immsrc=01.
//  4 sub (0110011, f3=000, f7b5=1) ->alucontrol 001; addi f7b5=1 ->000; or ->011.
//  5 beq zero=1 -> pcwrite=1 cycle 3; zero=0 -> pcwrite=0; immsrc=10.
//  6 op 0000000: TRAP_EN -> illegal=1 held 10 cycles, all writes 0; else FETCH
//    after DECODE, illegal=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I main controller: Moore FSM stepping fetch/decode/execute/mem/writeback.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles; no backpressure. Optional MC_ILLEGAL_TRAP_EN parks unknown ops in TRAP.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [2:0] alucontrol,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       illegal
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECR    = STATE_W'(6),
        S_EXECI    = STATE_W'(7),
        S_ALUWB    = STATE_W'(8),
        S_JAL      = STATE_W'(9),
        S_BEQ      = STATE_W'(10),
        S_TRAP     = STATE_W'(11)
    } state_t;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [1:0] aluop;
    logic       branch;
    logic       pcupdate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        aluop     = 2'b00;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = 1'b1;
                pcupdate  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target from OldPC + immext
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100011:             state_d = S_BEQ;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
`else
                        state_d   = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            7'b0100011: immsrc = 2'b01;
            7'b1100011: immsrc = 2'b10;
            7'b1101111: immsrc = 2'b11;
            default:    immsrc = 2'b00;
        endcase
    end

    assign pcwrite = pcupdate | (branch & zero);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected control words queued per instruction, compared each cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
    logic [2:0] alucontrol;
    logic       adrsrc, irwrite, pcwrite, memwrite, regwrite, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MW = 5;
    localparam int ST_ER = 6, ST_EI = 7, ST_AWB = 8, ST_J = 9, ST_B = 10, ST_T = 11;

    logic [16:0] exp_q[$];
    logic [16:0] dut_vec;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .alucontrol (alucontrol),
        .adrsrc     (adrsrc),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign dut_vec = {immsrc, alusrca, alusrcb, resultsrc, alucontrol,
                      adrsrc, irwrite, pcwrite, memwrite, regwrite, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control word for a given FSM step, written from the state table
    function automatic logic [16:0] exp_vec(input int st, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7, input logic z);
        logic [1:0] imm, a, b, r, aop;
        logic [2:0] ac;
        logic adr, irw, pcw, mw, rw, ill;
        imm = 2'b00; a = 2'b00; b = 2'b00; r = 2'b00; aop = 2'b00; ac = 3'b000;
        adr = 0; irw = 0; pcw = 0; mw = 0; rw = 0; ill = 0;
        if (o == 7'b0100011) imm = 2'b01;
        else if (o == 7'b1100011) imm = 2'b10;
        else if (o == 7'b1101111) imm = 2'b11;
        case (st)
            ST_F:   begin b = 2'b10; r = 2'b10; irw = 1; pcw = 1; end
            ST_D:   begin a = 2'b01; b = 2'b01; end
            ST_MA:  begin a = 2'b10; b = 2'b01; end
            ST_MR:  adr = 1;
            ST_MWB: begin r = 2'b01; rw = 1; end
            ST_MW:  begin adr = 1; mw = 1; end
            ST_ER:  begin a = 2'b10; aop = 2'b10; end
            ST_EI:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            ST_AWB: rw = 1;
            ST_J:   begin a = 2'b01; b = 2'b10; pcw = 1; end
            ST_B:   begin a = 2'b10; aop = 2'b01; pcw = z; end
            ST_T:   ill = 1;
            default: ;
        endcase
        if (aop == 2'b01) ac = 3'b001;
        else if (aop == 2'b10) begin
            if (f3 == 3'b000) ac = (o[5] && f7) ? 3'b001 : 3'b000;
            else if (f3 == 3'b010) ac = 3'b101;
            else if (f3 == 3'b110) ac = 3'b011;
            else if (f3 == 3'b111) ac = 3'b010;
        end
        return {imm, a, b, r, ac, adr, irw, pcw, mw, rw, ill};
    endfunction

    // Called at a falling edge with the DUT in FETCH; leaves it at the next FETCH
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z);
        int sts[$];
        logic [16:0] e;
        int cyc;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        case (o)
            7'b0000011: sts = '{ST_F, ST_D, ST_MA, ST_MR, ST_MWB};
            7'b0100011: sts = '{ST_F, ST_D, ST_MA, ST_MW};
            7'b0110011: sts = '{ST_F, ST_D, ST_ER, ST_AWB};
            7'b0010011: sts = '{ST_F, ST_D, ST_EI, ST_AWB};
            7'b1101111: sts = '{ST_F, ST_D, ST_J, ST_AWB};
            7'b1100011: sts = '{ST_F, ST_D, ST_B};
            default: begin
                sts = '{ST_F, ST_D};
`ifdef MC_ILLEGAL_TRAP_EN
                for (int k = 0; k < 10; k++) sts.push_back(ST_T);
`endif
            end
        endcase
        foreach (sts[k]) exp_q.push_back(exp_vec(sts[k], o, f3, f7, z));
        cyc = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            #1;
            check($sformatf("%s_c%0d", name, cyc), {15'd0, dut_vec}, {15'd0, e});
            @(negedge clk);
            cyc++;
        end
    endtask

    // Asserts rst_n at a falling edge, checks FETCH outputs during reset, releases after a rising edge
    task automatic reset_check(input string name);
        #1 rst_n = 1'b0;
        #1;
        check({name, "_irwrite"}, {31'd0, irwrite}, 32'd1);
        check({name, "_pcwrite"}, {31'd0, pcwrite}, 32'd1);
        check({name, "_regwrite"}, {31'd0, regwrite}, 32'd0);
        check({name, "_illegal"}, {31'd0, illegal}, 32'd0);
        check({name, "_vec"}, {15'd0, dut_vec}, {15'd0, exp_vec(ST_F, op, funct3, funct7b5, zero)});
        @(posedge clk);
        #1;
        check({name, "_hold"}, {15'd0, dut_vec}, {15'd0, exp_vec(ST_F, op, funct3, funct7b5, zero)});
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
        @(negedge clk);
        reset_check("por");

        run_instr("lw",    7'b0000011, 3'b010, 1'b0, 1'b0);
        run_instr("sw",    7'b0100011, 3'b010, 1'b0, 1'b0);
        run_instr("add",   7'b0110011, 3'b000, 1'b0, 1'b0);
        run_instr("sub",   7'b0110011, 3'b000, 1'b1, 1'b0);
        run_instr("or",    7'b0110011, 3'b110, 1'b0, 1'b0);
        run_instr("and",   7'b0110011, 3'b111, 1'b0, 1'b0);
        run_instr("slt",   7'b0110011, 3'b010, 1'b0, 1'b0);
        run_instr("addi",  7'b0010011, 3'b000, 1'b1, 1'b0);
        run_instr("ori",   7'b0010011, 3'b110, 1'b0, 1'b0);
        run_instr("sll",   7'b0110011, 3'b001, 1'b0, 1'b0);
        run_instr("jal",   7'b1101111, 3'b000, 1'b0, 1'b0);
        run_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1);
        run_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0);

        // lw interrupted by reset in MEMREAD
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_memread_adrsrc", {31'd0, adrsrc}, 32'd1);
        reset_check("rst_memread");
        run_instr("lw_after_rst", 7'b0000011, 3'b010, 1'b0, 1'b0);

        run_instr("illegal_op", 7'b0000000, 3'b000, 1'b0, 1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
        #1 check("trap_still_illegal", {31'd0, illegal}, 32'd1);
        reset_check("rst_trap");
`else
        #1 check("noop_illegal_low", {31'd0, illegal}, 32'd0);
`endif
        run_instr("add_after_illegal", 7'b0110011, 3'b000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
